// File: rtl/delay_pkg.sv
// Shared types and defaults for the audio delay-line sequencer.
package delay_pkg;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 9;
  localparam int unsigned DEFAULT_DATA_WIDTH    = 8;
  localparam int unsigned MIN_DELAY             = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;
endpackage

// File: rtl/delay_line_ctrl.sv
// Circular-buffer sequencer: writes each accepted sample at wr_ptr and reads the
// sample written d samples earlier, producing a fixed-delay output stream.
module delay_line_ctrl
  import delay_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     sample_valid,
  input  logic [DATA_WIDTH-1:0]    sample_in,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic                     ram_wr_en,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic                     ram_rd_en,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    sample_out,
  output logic                     primed
);

  state_t                   r_state, w_state_nx;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr, w_wr_ptr_nx;
  logic [ADDRESS_WIDTH-1:0] r_fill_cnt, w_fill_cnt_nx;
  logic [ADDRESS_WIDTH-1:0] r_offset_q, w_offset_q_nx;
  logic                     r_out_valid;
  logic                     r_mute_q;

  logic [ADDRESS_WIDTH-1:0] w_d;
  logic [ADDRESS_WIDTH-1:0] w_fill_inc;
  logic                     w_wr;
  logic                     w_rd;

  assign w_d        = (offset == '0) ? ADDRESS_WIDTH'(MIN_DELAY) : offset;
  assign w_fill_inc = r_fill_cnt + ADDRESS_WIDTH'(1);
  assign w_wr       = sample_valid && ((r_state == PRIME) || (r_state == RUN));
  assign w_rd       = sample_valid && (r_state == RUN);

  // RAM controls are driven to zero whenever no access is issued.
  always_comb begin
    ram_wr_en   = w_wr;
    ram_wr_addr = '0;
    ram_din     = '0;
    ram_rd_en   = w_rd;
    ram_rd_addr = '0;
    if (w_wr) begin
      ram_wr_addr = r_wr_ptr;
      ram_din     = sample_in;
    end
    if (w_rd) begin
      ram_rd_addr = r_wr_ptr - r_offset_q;
    end
  end

  assign out_valid  = r_out_valid;
  assign sample_out = r_mute_q ? '0 : ram_dout;
  assign primed     = (r_state == RUN);

  always_comb begin
    w_state_nx    = r_state;
    w_wr_ptr_nx   = r_wr_ptr;
    w_fill_cnt_nx = r_fill_cnt;
    w_offset_q_nx = r_offset_q;
    if (w_wr) begin
      w_wr_ptr_nx = r_wr_ptr + ADDRESS_WIDTH'(1);
    end
    unique case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nx    = PRIME;
          w_offset_q_nx = w_d;
          w_wr_ptr_nx   = '0;
          w_fill_cnt_nx = '0;
        end
      end
      PRIME, RUN: begin
        // Disable wins over an offset change; the current sample is still written.
        if (!en) begin
          w_state_nx = IDLE;
        end else if (w_d != r_offset_q) begin
          w_state_nx    = PRIME;
          w_offset_q_nx = w_d;
          w_fill_cnt_nx = '0;
        end else if (w_wr && (r_state == PRIME)) begin
          w_fill_cnt_nx = w_fill_inc;
          if (w_fill_inc == r_offset_q) begin
            w_state_nx = RUN;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_offset_q  <= ADDRESS_WIDTH'(MIN_DELAY);
      r_out_valid <= 1'b0;
      r_mute_q    <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_wr_ptr    <= w_wr_ptr_nx;
      r_fill_cnt  <= w_fill_cnt_nx;
      r_offset_q  <= w_offset_q_nx;
      r_out_valid <= w_wr;
      r_mute_q    <= !w_rd;
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl with a behavioural RAM and reference model.
module tb_delay_line_ctrl;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          sample_valid;
  logic [DW-1:0] sample_in;
  logic [AW-1:0] offset;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_din;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_dout;
  logic          out_valid;
  logic [DW-1:0] sample_out;
  logic          primed;

  always #5 clk = ~clk;

  delay_line_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sample_valid(sample_valid),
    .sample_in(sample_in), .offset(offset),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout),
    .out_valid(out_valid), .sample_out(sample_out), .primed(primed)
  );

  // Behavioural 512x8 RAM with registered read.
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
    if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of every accepted sample indexed by write count.
  logic [DW-1:0] hist [4096];
  int m_mode;   // 0 idle, 1 filling, 2 delaying
  int m_abs;
  int m_fill;
  int m_d;
  int m_ov;
  int m_out;
  logic [AW-1:0] last_rd_addr;

  task automatic model_reset();
    m_mode = 0; m_abs = 0; m_fill = 0; m_d = 1; m_ov = 0; m_out = 0;
  endtask

  task automatic step(input logic e, input logic v, input logic [DW-1:0] din,
                      input logic [AW-1:0] off);
    int dd, ewr, erd, raddr, nov, nout;
    en = e; sample_valid = v; sample_in = din; offset = off;
    @(negedge clk);
    dd    = (off == 0) ? 1 : int'(off);
    ewr   = (v && m_mode != 0) ? 1 : 0;
    erd   = (v && m_mode == 2) ? 1 : 0;
    raddr = erd ? (((m_abs - m_d) % DEPTH) + DEPTH) % DEPTH : 0;
    chk("ram_wr_en",   32'(ram_wr_en),   32'(ewr));
    chk("ram_wr_addr", 32'(ram_wr_addr), ewr ? 32'(m_abs % DEPTH) : 0);
    chk("ram_din",     32'(ram_din),     ewr ? 32'(din) : 0);
    chk("ram_rd_en",   32'(ram_rd_en),   32'(erd));
    chk("ram_rd_addr", 32'(ram_rd_addr), 32'(raddr));
    chk("out_valid",   32'(out_valid),   32'(m_ov));
    chk("sample_out",  32'(sample_out),  32'(m_out));
    chk("primed",      32'(primed),      (m_mode == 2) ? 1 : 0);
    last_rd_addr = ram_rd_addr;
    nov  = ewr;
    nout = erd ? int'(hist[(m_abs - m_d) % 4096]) : 0;
    if (ewr != 0) begin
      hist[m_abs % 4096] = din;
      m_abs++;
    end
    if (m_mode == 0) begin
      if (e) begin m_mode = 1; m_d = dd; m_abs = 0; m_fill = 0; end
    end else if (!e) begin
      m_mode = 0;
    end else if (dd != m_d) begin
      m_mode = 1; m_d = dd; m_fill = 0;
    end else if (ewr != 0 && m_mode == 1) begin
      m_fill++;
      if (m_fill == m_d) m_mode = 2;
    end
    m_ov = nov; m_out = nout;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          e;
    logic          v;
    logic [DW-1:0] din;
    logic [AW-1:0] off;
    logic          x_ov;
    logic [DW-1:0] x_out;
    logic          x_primed;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1, 0,  0, 3, 0,  0, 0};
    tbl[1]  = '{1, 1, 10, 3, 0,  0, 0};
    tbl[2]  = '{1, 1, 20, 3, 1,  0, 0};
    tbl[3]  = '{1, 1, 30, 3, 1,  0, 0};
    tbl[4]  = '{1, 1, 40, 3, 1,  0, 1};
    tbl[5]  = '{1, 1, 50, 3, 1, 10, 1};
    tbl[6]  = '{1, 0,  0, 3, 1, 20, 1};
    tbl[7]  = '{0, 0,  0, 3, 0,  0, 1};
    tbl[8]  = '{1, 0,  0, 0, 0,  0, 0};
    tbl[9]  = '{1, 1,  7, 0, 0,  0, 0};
    tbl[10] = '{1, 1,  8, 0, 1,  0, 1};
    tbl[11] = '{1, 1,  9, 0, 1,  7, 1};
    tbl[12] = '{1, 0,  0, 0, 1,  8, 1};
    tbl[13] = '{0, 0,  0, 0, 0,  0, 1};
    tbl[14] = '{0, 0,  0, 0, 0,  0, 0};

    rst_n = 1'b0; en = 0; sample_valid = 0; sample_in = 8'hA5; offset = 3;
    model_reset();
    #12;
    chk("rst_ram_wr_en", 32'(ram_wr_en), 0);
    chk("rst_ram_din",   32'(ram_din),   0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sample_out",32'(sample_out),0);
    chk("rst_primed",    32'(primed),    0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table vectors: basic priming (d=3) then offset=0 clamping to d=1.
    for (int i = 0; i < 15; i++) begin
      en = tbl[i].e; sample_valid = tbl[i].v; sample_in = tbl[i].din; offset = tbl[i].off;
      @(negedge clk);
      chk($sformatf("tbl%0d_out_valid", i),  32'(out_valid),  32'(tbl[i].x_ov));
      chk($sformatf("tbl%0d_sample_out", i), 32'(sample_out), 32'(tbl[i].x_out));
      chk($sformatf("tbl%0d_primed", i),     32'(primed),     32'(tbl[i].x_primed));
      @(posedge clk); #1;
    end

    // Long incrementing stream with d=5 across the pointer wrap.
    step(1, 0, 0, 5);
    for (int i = 0; i < 600; i++) begin
      step(1, 1, 8'(i % 256), 5);
      if (i == 514) chk("rd_addr_wrap", 32'(last_rd_addr), 509);
    end

    // Offset change 4 -> 2 while delaying.
    step(0, 0, 0, 5);
    step(1, 0, 0, 4);
    for (int i = 0; i < 8; i++) step(1, 1, 8'(100 + i), 4);
    for (int i = 0; i < 6; i++) step(1, 1, 8'(150 + i), 2);

    // Gaps in sample_valid.
    step(1, 1, 8'd61, 2);
    step(1, 0, 8'd62, 2);
    step(1, 0, 8'd63, 2);
    step(1, 1, 8'd64, 2);
    step(1, 0, 8'd65, 2);

    // Asynchronous reset between edges while delaying.
    en = 1; sample_valid = 1; sample_in = 8'd77; offset = 2;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ram_wr_en",   32'(ram_wr_en),   0);
    chk("arst_ram_rd_en",   32'(ram_rd_en),   0);
    chk("arst_ram_wr_addr", 32'(ram_wr_addr), 0);
    chk("arst_ram_din",     32'(ram_din),     0);
    chk("arst_out_valid",   32'(out_valid),   0);
    chk("arst_sample_out",  32'(sample_out),  0);
    chk("arst_primed",      32'(primed),      0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 0, 0, 3);
    step(1, 1, 8'd1, 3);
    for (int i = 0; i < 5; i++) step(1, 1, 8'(2 + i), 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic re, rv;
      logic [AW-1:0] ro;
      re = ($urandom_range(0, 199) != 0);
      rv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 79) == 0)
        ro = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                         : AW'($urandom_range(0, 12));
      else
        ro = offset;
      step(re, rv, DW'($urandom), ro);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
